// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definitions (package)
// Description : Shared types for the accumulator core control path: the
//               instruction opcode enum, the control sequencer state enum and
//               opcode-class helpers used to decode write enables.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions;

    // Upper five bits of the 9-bit instruction word.
    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_MOV   = 5'd1,
        OP_IMOV  = 5'd2,
        OP_MOVTO = 5'd3,
        OP_CMP   = 5'd4,
        OP_ICMP  = 5'd5,
        OP_LSL   = 5'd6,
        OP_LSR   = 5'd7,
        OP_AND   = 5'd8,
        OP_OR    = 5'd9,
        OP_XOR   = 5'd10,
        OP_ADD   = 5'd11,
        OP_IADD  = 5'd12,
        OP_SUB   = 5'd13,
        OP_ISUB  = 5'd14,
        OP_MOD   = 5'd15,
        OP_ABS   = 5'd16,
        OP_LDR   = 5'd17,
        OP_RLDR  = 5'd18,
        OP_STR   = 5'd19,
        OP_LDROV = 5'd20,
        OP_CLROV = 5'd21,
        OP_B     = 5'd22,
        OP_BEQ   = 5'd23,
        OP_BLE   = 5'd24,
        OP_BGE   = 5'd25,
        OP_HALT  = 5'd31
    } op_code;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } ctrl_state_e;

    // Instructions that need a data-memory transaction.
    function automatic logic is_mem(input logic [4:0] op);
        logic r;
        case (op)
            OP_LDR, OP_RLDR, OP_STR: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions that update the accumulator in writeback.
    function automatic logic writes_acc(input logic [4:0] op);
        logic r;
        case (op)
            OP_MOV, OP_IMOV, OP_CMP, OP_ICMP, OP_LSL, OP_LSR,
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_IADD, OP_SUB, OP_ISUB,
            OP_MOD, OP_ABS, OP_LDR, OP_RLDR, OP_LDROV: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions that update the overflow flag in writeback.
    function automatic logic writes_ov(input logic [4:0] op);
        logic r;
        case (op)
            OP_ADD, OP_IADD, OP_SUB, OP_ISUB, OP_CLROV: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_ctrl_counters.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_counters
// Description : Per-run cycle and retired-instruction counters. Both are
//               synchronously cleared, count when enabled and hold at
//               all-ones instead of wrapping.
// Ports       : CLK, reset_n      - clock, async active-low reset
//               clear             - zero both counters (start of a run)
//               cyc_en / ins_en   - increment enables
//               cycle_cnt/instr_cnt - counter values
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_counters #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             cyc_en,
    input  logic             ins_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (clear) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (cyc_en && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (ins_en && (r_instr_cnt != '1)) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl
// Description : Multi-cycle control sequencer for the accumulator core.
//               Fetches an instruction into the instruction register, then
//               steps it through EXEC, optional MEM and WB. Owns the PC,
//               the start/done run handshake and per-run counters.
// Ports       : CLK, reset_n                 - clock, async active-low reset
//               start, start_addr            - run request and entry PC
//               instr                        - ROM data at pc_o
//               jump_bit, alu_result         - ALU branch decision / target
//               mem_ack                      - data memory completion
//               pc_o, ir_o                   - PC and instruction register
//               mem_req, mem_we              - data memory request / write
//               acc_we, reg_we, ov_we        - writeback enables
//               done, err                    - run finished / memory timeout
//               cycle_cnt, instr_cnt         - per-run counters
// Revision    : 1.0 - initial release
// ============================================================================
module core_ctrl
    import definitions::*;
#(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic [8:0]       instr,
    input  logic             jump_bit,
    input  logic [7:0]       alu_result,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc_o,
    output logic [8:0]       ir_o,
    output logic             mem_req,
    output logic             mem_we,
    output logic             acc_we,
    output logic             reg_we,
    output logic             ov_we,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // r_wait counts completed MEM cycles, so the MEM_TIMEOUT-th cycle sees
    // MEM_TIMEOUT-1. An ack on that cycle still wins over the timeout.
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_next_pc;
    logic [PC_W-1:0] w_branch_pc;
    logic [8:0]      r_ir;
    logic            r_err;
    logic [c_WAIT_W-1:0] r_wait;
    logic [4:0]      w_op;
    logic            w_start_acc;
    logic            w_mem_timeout;
    logic            w_retire;
    logic            w_cyc_en;

    assign w_op = r_ir[8:4];

    generate
        if (PC_W <= 8) begin : g_pc_narrow
            assign w_branch_pc = alu_result[PC_W-1:0];
        end else begin : g_pc_wide
            assign w_branch_pc = {{(PC_W-8){1'b0}}, alu_result};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and sequencing strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_start_acc   = 1'b0;
        w_mem_timeout = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_start_acc = 1'b1;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = S_DONE;
                    w_retire    = 1'b1;
                end else if (is_mem(w_op)) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    w_state_nxt = S_WB;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_mem_timeout = 1'b1;
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, instruction register, error flag and MEM wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= '0;
            r_next_pc <= '0;
            r_ir      <= '0;
            r_err     <= 1'b0;
            r_wait    <= '0;
        end else begin
            if (w_start_acc) begin
                r_pc  <= start_addr;
                r_err <= 1'b0;
            end
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
            // The redirect is captured in EXEC so that the ALU inputs only
            // need to be valid for that one cycle; WB commits it.
            if (r_state == S_EXEC) begin
                r_next_pc <= jump_bit ? w_branch_pc : (r_pc + 1'b1);
            end
            if (r_state == S_WB) begin
                r_pc <= r_next_pc;
            end
            if (w_mem_timeout) begin
                r_err <= 1'b1;
            end
            r_wait <= (r_state == S_MEM) ? (r_wait + 1'b1) : '0;
        end
    end

    assign w_cyc_en = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                      (r_state == S_MEM)   || (r_state == S_WB);

    ctrl_counters #(
        .CNT_W (CNT_W)
    ) u_counters (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .clear     (w_start_acc),
        .cyc_en    (w_cyc_en),
        .ins_en    (w_retire),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs: decoded from state and the instruction register only
    // ------------------------------------------------------------------
    assign pc_o    = r_pc;
    assign ir_o    = r_ir;
    assign mem_req = (r_state == S_MEM);
    assign mem_we  = (r_state == S_MEM) && (w_op == OP_STR);
    assign acc_we  = (r_state == S_WB) && writes_acc(w_op);
    assign reg_we  = (r_state == S_WB) && (w_op == OP_MOVTO);
    assign ov_we   = (r_state == S_WB) && writes_ov(w_op);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_ctrl
// Description : Self-checking bench for core_ctrl. A ROM array and per-PC
//               tables of branch decision, branch target and memory ack
//               delay drive the DUT; an instruction-level model predicts
//               latency, enable pulses, next PC and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ctrl;
    import definitions::*;

    localparam int PC_W        = 8;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;

    logic             CLK;
    logic             reset_n;
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic [8:0]       instr;
    logic             jump_bit;
    logic [7:0]       alu_result;
    logic             mem_ack;
    logic [PC_W-1:0]  pc_o;
    logic [8:0]       ir_o;
    logic             mem_req, mem_we, acc_we, reg_we, ov_we, done, err;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    logic [8:0] rom     [0:255];
    logic       j_tab   [0:255];
    logic [7:0] a_tab   [0:255];
    int         ack_tab [0:255];   // 0: never ack, else ack on that MEM cycle

    int tests = 0;
    int fails = 0;

    // Model state
    logic [7:0] m_pc;
    int         m_cyc;
    int         m_ins;
    logic       m_err;

    assign instr = rom[pc_o];

    core_ctrl #(
        .PC_W        (PC_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .instr      (instr),
        .jump_bit   (jump_bit),
        .alu_result (alu_result),
        .mem_ack    (mem_ack),
        .pc_o       (pc_o),
        .ir_o       (ir_o),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .acc_we     (acc_we),
        .reg_we     (reg_we),
        .ov_we      (ov_we),
        .done       (done),
        .err        (err),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Writeback classes, straight from the instruction set description.
    function automatic bit exp_acc(input logic [4:0] op);
        case (op)
            OP_MOV, OP_IMOV, OP_CMP, OP_ICMP, OP_LSL, OP_LSR, OP_AND, OP_OR,
            OP_XOR, OP_ADD, OP_IADD, OP_SUB, OP_ISUB, OP_MOD, OP_ABS,
            OP_LDR, OP_RLDR, OP_LDROV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_ov(input logic [4:0] op);
        case (op)
            OP_ADD, OP_IADD, OP_SUB, OP_ISUB, OP_CLROV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},      pc_o, 0);
        check({tag, "_ir"},      ir_o, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"},  mem_we, 0);
        check({tag, "_enables"}, {acc_we, reg_we, ov_we}, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_err"},     err, 0);
        check({tag, "_cyc"},     cycle_cnt, 0);
        check({tag, "_ins"},     instr_cnt, 0);
    endtask

    task automatic start_run(input logic [7:0] addr);
        start_addr = addr;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        m_pc  = addr;
        m_cyc = 0;
        m_ins = 0;
        m_err = 1'b0;
        check("start_pc",   pc_o, addr);
        check("start_cyc",  cycle_cnt, 0);
        check("start_ins",  instr_cnt, 0);
        check("start_done", done, 0);
        check("start_err",  err, 0);
    endtask

    // Runs one instruction from its FETCH cycle to the next FETCH (or DONE).
    task automatic run_instr(input bit noise, output bit halted);
        logic [4:0] op;
        bit         mem_op, tmo;
        int         n, len, c_req, c_we, stray, exp_req;
        logic       l_acc, l_reg, l_ov;
        halted = 1'b0;
        check("fetch_pc", pc_o, m_pc);
        op     = rom[m_pc][8:4];
        mem_op = (op == OP_LDR) || (op == OP_RLDR) || (op == OP_STR);
        n      = ack_tab[m_pc];
        tmo    = mem_op && (n == 0);
        if (op == OP_HALT)  len = 2;
        else if (tmo)       len = 2 + MEM_TIMEOUT;
        else if (mem_op)    len = 3 + n;
        else                len = 3;
        jump_bit   = j_tab[m_pc];
        alu_result = a_tab[m_pc];
        c_req = 0; c_we = 0; stray = 0;
        l_acc = 1'b0; l_reg = 1'b0; l_ov = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (mem_op && k >= 2 && (tmo || k <= 1 + n))
                mem_ack = !tmo && (k == 1 + n);
            else
                mem_ack = 1'($urandom);
            if (noise) start = 1'($urandom);
            if (mem_req) c_req++;
            if (mem_we)  c_we++;
            if (k == len - 1) begin
                l_acc = acc_we; l_reg = reg_we; l_ov = ov_we;
            end else if (acc_we || reg_we || ov_we || done) begin
                stray++;
            end
            tick();
        end
        mem_ack  = 1'b0;
        start    = 1'b0;
        jump_bit = 1'b0;

        exp_req = tmo ? MEM_TIMEOUT : (mem_op ? n : 0);
        check("mem_req_cycles", c_req, exp_req);
        check("mem_we_cycles",  c_we, (op == OP_STR) ? exp_req : 0);
        check("acc_we_wb", l_acc, (!tmo && op != OP_HALT) ? exp_acc(op) : 1'b0);
        check("reg_we_wb", l_reg, (op == OP_MOVTO) ? 1 : 0);
        check("ov_we_wb",  l_ov, exp_ov(op) ? 1 : 0);
        check("stray_pulses", stray, 0);

        m_cyc += len;
        if (op == OP_HALT) begin
            m_ins++;
            halted = 1'b1;
        end else if (tmo) begin
            m_err  = 1'b1;
            halted = 1'b1;
        end else begin
            m_ins++;
            m_pc = j_tab[m_pc] ? a_tab[m_pc] : (m_pc + 8'd1);
        end
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("instr_cnt", instr_cnt, m_ins);
        check("done",      done, halted);
        check("err",       err, m_err);
    endtask

    task automatic run_program(input logic [7:0] addr, input int max_instr, input bit noise);
        bit halted;
        halted = 1'b0;
        start_run(addr);
        for (int i = 0; i < max_instr && !halted; i++) begin
            if (i == max_instr - 1) rom[m_pc] = {OP_HALT, 4'h0};
            run_instr(noise, halted);
        end
        check("run_halted", halted, 1);
        tick();
        tick();
        check("done_hold",  done, 1);
        check("cyc_frozen", cycle_cnt, m_cyc);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 256; i++) begin
            rom[i]     = {OP_NOP, 4'h0};
            j_tab[i]   = 1'b0;
            a_tab[i]   = 8'h00;
            ack_tab[i] = 1;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        jump_bit   = 1'b0;
        alu_result = '0;
        mem_ack    = 1'b0;
        clear_tables();

        // Power-on reset
        tick(); tick(); tick();
        check_reset_outputs("por");
        reset_n = 1'b1;
        tick(); tick();
        check("idle_cyc",  cycle_cnt, 0);
        check("idle_done", done, 0);

        // Asynchronous reset while a load sits in MEM
        rom[8'h40] = {OP_LDR, 4'h3};
        start_run(8'h40);
        tick(); tick();
        check("mid_mem_req", mem_req, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        #1 reset_n = 1'b1;
        tick(); tick();
        check("post_rst_pc",  pc_o, 0);
        check("post_rst_cyc", cycle_cnt, 0);
        check("post_rst_req", mem_req, 0);

        // ADD, MOVTO, HALT from 0x10
        clear_tables();
        rom[8'h10] = {OP_ADD,   4'h1};
        rom[8'h11] = {OP_MOVTO, 4'h2};
        rom[8'h12] = {OP_HALT,  4'h0};
        run_program(8'h10, 10, 1'b0);
        check("prog_ins", instr_cnt, 3);
        check("prog_cyc", cycle_cnt, 8);

        // BEQ taken and not taken
        rom[8'h05] = {OP_BEQ, 4'h0};
        j_tab[8'h05] = 1'b1;
        a_tab[8'h05] = 8'h20;
        rom[8'h20] = {OP_HALT, 4'h0};
        rom[8'h06] = {OP_HALT, 4'h0};
        run_program(8'h05, 10, 1'b0);
        j_tab[8'h05] = 1'b0;
        run_program(8'h05, 10, 1'b0);

        // STR acked on the fourth MEM cycle
        rom[8'h30] = {OP_STR, 4'h5};
        ack_tab[8'h30] = 4;
        rom[8'h31] = {OP_HALT, 4'h0};
        run_program(8'h30, 10, 1'b0);

        // LDR never acked, then a fresh start clears err
        rom[8'h40] = {OP_LDR, 4'h0};
        ack_tab[8'h40] = 0;
        run_program(8'h40, 10, 1'b0);
        check("tmo_err", err, 1);

        // Ack on the last permitted MEM cycle
        rom[8'h50] = {OP_RLDR, 4'h0};
        ack_tab[8'h50] = MEM_TIMEOUT;
        rom[8'h51] = {OP_HALT, 4'h0};
        run_program(8'h50, 10, 1'b0);

        // PC wrap from 0xFF
        rom[8'hFF] = {OP_MOV, 4'h0};
        rom[8'h00] = {OP_HALT, 4'h0};
        run_program(8'hFF, 10, 1'b0);

        // Random programs with start/mem_ack noise
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 256; i++) begin
                rom[i]   = {5'($urandom_range(0, 31)), 4'($urandom)};
                j_tab[i] = 1'($urandom);
                a_tab[i] = 8'($urandom);
                ack_tab[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MEM_TIMEOUT));
            end
            run_program(8'($urandom), 30, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
